id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of out_pc.
REQ-002 SHALL have parameter INST_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter IMM_TYPE_NUM, default 4, number of immediate formats; out_imm_type width is $clog2(IMM_TYPE_NUM).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous, active-low reset).
REQ-005 SHALL have ports in_valid input 1 (fetch word valid); in_ready output 1 (stage can accept); in_inst input INST_WIDTH (fetched instruction); in_pc input DATA_WIDTH (instruction address).
REQ-006 SHALL have port flush input 1 (discard all held instructions).
REQ-007 SHALL have ports out_valid output 1 (decoded entry valid); out_ready input 1 (downstream accepts); out_inst output INST_WIDTH (feeds immediate generator); out_pc output DATA_WIDTH.
REQ-008 SHALL have ports out_imm_type output 2 (immediate-format select); out_rs1, out_rs2, out_rd output 5 each (inst[19:15], inst[24:20], inst[11:7]); out_illegal output 1 (unsupported opcode).

Function
REQ-009 SHALL hold up to two entries, a main register driving the outputs and a skid register, giving three states: EMPTY, ONE, FULL.
REQ-010 A transfer in SHALL occur when in_valid and in_ready are high; a transfer out SHALL occur when out_valid and out_ready are high.
REQ-011 in_ready SHALL be high in EMPTY and ONE and low in FULL, and SHALL be driven from state registers only, with no combinational path from out_ready.
REQ-012 EMPTY + transfer in -> ONE; new entry appears on outputs the next cycle (1-cycle latency).
REQ-013 ONE + transfer in + transfer out -> ONE with the new entry in main; ONE + transfer in only -> FULL with the new entry in skid; ONE + transfer out only -> EMPTY.
REQ-014 FULL + transfer out -> ONE with skid moved to main; no entry SHALL be lost or duplicated, and order SHALL be preserved.
REQ-015 out_valid SHALL be high exactly in ONE and FULL; while out_valid is high and out_ready is low, all out_* SHALL stay stable.
REQ-016 Decode SHALL be computed at capture and registered with the entry, so out_* are register outputs.
REQ-017 Opcode 0010011 with funct3 001 or 101 SHALL give out_imm_type 01 (shift).
REQ-018 Opcode 0100011 SHALL give out_imm_type 10 (store).
REQ-019 Opcode 0110111 or 0010111 SHALL give out_imm_type 11 (upper immediate).
REQ-020 All other opcodes SHALL give out_imm_type 00 (I-format).
REQ-021 out_illegal SHALL be high when the opcode is none of 0110011, 0010011, 0000011, 0100011, 0110111, 0010111, 1100111, 1100011, 1101111, 1110011, 0011011, 0111011; an illegal entry still flows through the handshake normally.
REQ-022 flush high at a rising edge SHALL force state EMPTY, overriding any simultaneous transfer in or out; an in_valid presented that cycle SHALL be dropped.
REQ-023 After flush, in_ready SHALL be high the next cycle.

Reset
REQ-024 On rst_n low, state SHALL go to EMPTY immediately, regardless of clk.
REQ-025 During reset, out_valid=0, in_ready=1, and out_inst, out_pc, out_imm_type, out_rs1, out_rs2, out_rd, out_illegal = 0.
REQ-026 Reset mid-transfer SHALL discard both entries; the first accepted entry after rst_n rises SHALL be the first one output.

Configuration
REQ-027 Macro ID_STAGE_ILLEGAL_EN defined: out_illegal SHALL behave per REQ-021.
REQ-028 Macro ID_STAGE_ILLEGAL_EN undefined: out_illegal SHALL be constant 0, and no opcode-check logic or storage bit SHALL be present.

Verification
REQ-029 in_inst=0x00A00093, in_pc=0x1000, out_ready=1 -> next cycle out_valid=1, out_imm_type=00, out_rd=1, out_rs1=0, out_pc=0x1000, out_illegal=0.
REQ-030 Send 0x00309113 (shift), 0x0020B423 (store), 0x123452B7 (upper immediate) back-to-back with out_ready=1 -> out_imm_type 01, 10, 11 on three consecutive cycles; the store has out_rs1=1, out_rs2=2.
REQ-031 out_ready=0 while sending pc 0x0, 0x4 -> in_ready=0 after the 2nd accept; hold 5 cycles, then out_ready=1 -> outputs pc 0x0 then 0x4; no loss.
REQ-032 FULL state, then flush=1 with in_valid=1 (pc 0x8) -> next cycle out_valid=0, in_ready=1; pc 0x8 is never output.
REQ-033 in_inst=0x0000007F -> out_illegal=1 with ID_STAGE_ILLEGAL_EN defined, and 0 without it.
REQ-034 Assert rst_n=0 asynchronously mid-cycle in FULL -> out_valid=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage with a two-entry skid buffer (main + skid) and registered decode fields.
// Optional opcode legality check is enabled by defining ID_STAGE_ILLEGAL_EN.
module id_stage #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned INST_WIDTH   = 32,
  parameter int unsigned IMM_TYPE_NUM = 4,
  localparam int unsigned ImmW        = $clog2(IMM_TYPE_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] in_inst,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [ImmW-1:0]       out_imm_type,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [4:0]            out_rd,
  output logic                  out_illegal
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e                r_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [INST_WIDTH-1:0] r_main_inst, r_skid_inst;
  logic [DATA_WIDTH-1:0] r_main_pc, r_skid_pc;
  logic [ImmW-1:0]       r_main_imm, r_skid_imm;

  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_main_from_in;
  logic                  w_main_from_skid;
  logic                  w_skid_from_in;
  logic [ImmW-1:0]       w_new_imm;

  function automatic logic [ImmW-1:0] f_imm_type(input logic [6:0] opcode,
                                                 input logic [2:0] funct3);
    logic [ImmW-1:0] imm;
    imm = ImmW'(0);
    case (opcode)
      7'b0010011: if (funct3 == 3'b001 || funct3 == 3'b101) imm = ImmW'(1);
      7'b0100011: imm = ImmW'(2);
      7'b0110111,
      7'b0010111: imm = ImmW'(3);
      default:    imm = ImmW'(0);
    endcase
    return imm;
  endfunction

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;
  assign w_new_imm  = f_imm_type(in_inst[6:0], in_inst[14:12]);

  // Main takes the new word when the stage was empty or main drains the same cycle.
  assign w_main_from_in   = !flush && w_in_xfer &&
                            ((r_state == StEmpty) || (r_state == StOne && w_out_xfer));
  assign w_skid_from_in   = !flush && w_in_xfer && (r_state == StOne) && !w_out_xfer;
  assign w_main_from_skid = !flush && w_out_xfer && (r_state == StFull);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StEmpty;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= StEmpty;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_in_xfer) begin
            r_state     <= StOne;
            r_out_valid <= 1'b1;
          end
        end
        StOne: begin
          if (w_in_xfer && !w_out_xfer) begin
            r_state    <= StFull;
            r_in_ready <= 1'b0;
          end else if (!w_in_xfer && w_out_xfer) begin
            r_state     <= StEmpty;
            r_out_valid <= 1'b0;
          end
        end
        StFull: begin
          if (w_out_xfer) begin
            r_state    <= StOne;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= StEmpty;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_inst <= '0;
      r_main_pc   <= '0;
      r_main_imm  <= '0;
      r_skid_inst <= '0;
      r_skid_pc   <= '0;
      r_skid_imm  <= '0;
    end else begin
      if (w_main_from_in) begin
        r_main_inst <= in_inst;
        r_main_pc   <= in_pc;
        r_main_imm  <= w_new_imm;
      end else if (w_main_from_skid) begin
        r_main_inst <= r_skid_inst;
        r_main_pc   <= r_skid_pc;
        r_main_imm  <= r_skid_imm;
      end
      if (w_skid_from_in) begin
        r_skid_inst <= in_inst;
        r_skid_pc   <= in_pc;
        r_skid_imm  <= w_new_imm;
      end
    end
  end

`ifdef ID_STAGE_ILLEGAL_EN
  logic r_main_ill, r_skid_ill;
  logic w_new_ill;

  always_comb begin
    w_new_ill = 1'b1;
    case (in_inst[6:0])
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
      7'b0110111, 7'b0010111, 7'b1100111, 7'b1100011,
      7'b1101111, 7'b1110011, 7'b0011011, 7'b0111011: w_new_ill = 1'b0;
      default: w_new_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_ill <= 1'b0;
      r_skid_ill <= 1'b0;
    end else begin
      if (w_main_from_in) begin
        r_main_ill <= w_new_ill;
      end else if (w_main_from_skid) begin
        r_main_ill <= r_skid_ill;
      end
      if (w_skid_from_in) begin
        r_skid_ill <= w_new_ill;
      end
    end
  end

  assign out_illegal = r_main_ill;
`else
  assign out_illegal = 1'b0;
`endif

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_inst     = r_main_inst;
  assign out_pc       = r_main_pc;
  assign out_imm_type = r_main_imm;
  assign out_rs1      = r_main_inst[19:15];
  assign out_rs2      = r_main_inst[24:20];
  assign out_rd       = r_main_inst[11:7];

endmodule
